// File: rtl/mem_stack_ctrl.sv
// Memory-stage controller: loads/stores, stack push/pop, two-word PC save/restore,
// CCR save/restore and the interrupt entry sequence. Owns the stack pointer.
module mem_stack_ctrl #(
   parameter int ADDR_W = 11,
   parameter logic [ADDR_W-1:0] SP_INIT  = {ADDR_W{1'b1}},
   parameter logic [ADDR_W-1:0] INT1_VEC = ADDR_W'(2),
   parameter logic [ADDR_W-1:0] INT2_VEC = ADDR_W'(4)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       ALU_result,
   input  logic [15:0]       Rs_data,
   input  logic [15:0]       Rd_data,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic              push,
   input  logic              pop,
   input  logic              pushPc,
   input  logic              popPc,
   input  logic              pushCCR,
   input  logic              popCCR,
   input  logic              int1,
   input  logic              int2,
   input  logic [31:0]       pc_in,
   input  logic [2:0]        ccr_in,
   input  logic [15:0]       mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   output logic [15:0]       mem_result,
   output logic [31:0]       pc_out,
   output logic              pc_load,
   output logic [2:0]        ccr_out,
   output logic              ccr_load,
   output logic              stall,
   output logic [ADDR_W-1:0] sp
);

   // state       | meaning
   // IDLE        | accepts requests; single-cycle ops complete here
   // PUSH_PC_HI  | pushPc second access: write latched PC high word
   // POP_PC_LO   | popPc second access: read PC low word, load PC
   // INT_PC_HI   | interrupt: push latched PC high word
   // INT_CCR     | interrupt: push latched CCR
   // INT_VEC_HI  | interrupt: read vector high word
   // INT_VEC_LO  | interrupt: read vector low word, load PC
   typedef enum logic [2:0] {
      S_IDLE, S_PUSH_PC_HI, S_POP_PC_LO, S_INT_PC_HI, S_INT_CCR, S_INT_VEC_HI, S_INT_VEC_LO
   } state_t;

   typedef enum logic [3:0] {
      OP_NONE, OP_INT2, OP_INT1, OP_PUSH_PC, OP_POP_PC, OP_PUSH_CCR, OP_POP_CCR,
      OP_PUSH, OP_POP, OP_WRITE, OP_READ
   } op_t;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t            state, state_next;
   op_t               op;
   logic [ADDR_W-1:0] sp_next;
   logic [ADDR_W-1:0] vec;
   logic [15:0]       hi_word;
   logic [2:0]        ccr_hold;
   logic              we_raw, re_raw, stall_raw;

   // Rs_data and the upper address bits are not needed at this stage.
   logic unused_ok;
   assign unused_ok = ^{Rs_data, ALU_result[15:ADDR_W]};

   always_comb begin
      op = OP_NONE;
      if      (int2)     op = OP_INT2;
      else if (int1)     op = OP_INT1;
      else if (pushPc)   op = OP_PUSH_PC;
      else if (popPc)    op = OP_POP_PC;
      else if (pushCCR)  op = OP_PUSH_CCR;
      else if (popCCR)   op = OP_POP_CCR;
      else if (push)     op = OP_PUSH;
      else if (pop)      op = OP_POP;
      else if (memWrite) op = OP_WRITE;
      else if (memRead)  op = OP_READ;
   end

   always_comb begin
      state_next = state;
      sp_next    = sp;
      mem_addr   = '0;
      mem_wdata  = '0;
      we_raw     = 1'b0;
      re_raw     = 1'b0;
      stall_raw  = 1'b0;
      case (state)
         S_IDLE: begin
            case (op)
               OP_INT2, OP_INT1: begin
                  mem_addr = sp; mem_wdata = pc_in[15:0]; we_raw = 1'b1;
                  sp_next = sp - ONE; stall_raw = 1'b1; state_next = S_INT_PC_HI;
               end
               OP_PUSH_PC: begin
                  mem_addr = sp; mem_wdata = pc_in[15:0]; we_raw = 1'b1;
                  sp_next = sp - ONE; stall_raw = 1'b1; state_next = S_PUSH_PC_HI;
               end
               OP_POP_PC: begin
                  mem_addr = sp + ONE; re_raw = 1'b1;
                  sp_next = sp + ONE; stall_raw = 1'b1; state_next = S_POP_PC_LO;
               end
               OP_PUSH_CCR: begin
                  mem_addr = sp; mem_wdata = {13'b0, ccr_in}; we_raw = 1'b1; sp_next = sp - ONE;
               end
               OP_POP_CCR, OP_POP: begin
                  mem_addr = sp + ONE; re_raw = 1'b1; sp_next = sp + ONE;
               end
               OP_PUSH: begin
                  mem_addr = sp; mem_wdata = Rd_data; we_raw = 1'b1; sp_next = sp - ONE;
               end
               OP_WRITE: begin
                  mem_addr = ALU_result[ADDR_W-1:0]; mem_wdata = Rd_data; we_raw = 1'b1;
               end
               OP_READ: begin
                  mem_addr = ALU_result[ADDR_W-1:0]; re_raw = 1'b1;
               end
               default: ;
            endcase
         end
         S_PUSH_PC_HI: begin
            mem_addr = sp; mem_wdata = hi_word; we_raw = 1'b1;
            sp_next = sp - ONE; state_next = S_IDLE;
         end
         S_POP_PC_LO: begin
            mem_addr = sp + ONE; re_raw = 1'b1;
            sp_next = sp + ONE; state_next = S_IDLE;
         end
         S_INT_PC_HI: begin
            mem_addr = sp; mem_wdata = hi_word; we_raw = 1'b1;
            sp_next = sp - ONE; stall_raw = 1'b1; state_next = S_INT_CCR;
         end
         S_INT_CCR: begin
            mem_addr = sp; mem_wdata = {13'b0, ccr_hold}; we_raw = 1'b1;
            sp_next = sp - ONE; stall_raw = 1'b1; state_next = S_INT_VEC_HI;
         end
         S_INT_VEC_HI: begin
            mem_addr = vec; re_raw = 1'b1; stall_raw = 1'b1; state_next = S_INT_VEC_LO;
         end
         S_INT_VEC_LO: begin
            mem_addr = vec + ONE; re_raw = 1'b1; state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // A reset cycle must never disturb memory or hold the pipeline.
   assign mem_we = we_raw & ~reset;
   assign mem_re = re_raw & ~reset;
   assign stall  = stall_raw & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         sp         <= SP_INIT;
         mem_result <= '0;
         pc_out     <= '0;
         pc_load    <= 1'b0;
         ccr_out    <= '0;
         ccr_load   <= 1'b0;
         hi_word    <= '0;
         ccr_hold   <= '0;
         vec        <= '0;
      end else begin
         state    <= state_next;
         sp       <= sp_next;
         pc_load  <= 1'b0;
         ccr_load <= 1'b0;
         case (state)
            S_IDLE: begin
               mem_result <= (op == OP_READ || op == OP_POP) ? mem_rdata : ALU_result;
               case (op)
                  OP_INT2: begin
                     hi_word <= pc_in[31:16]; ccr_hold <= ccr_in; vec <= INT2_VEC;
                  end
                  OP_INT1: begin
                     hi_word <= pc_in[31:16]; ccr_hold <= ccr_in; vec <= INT1_VEC;
                  end
                  OP_PUSH_PC: hi_word <= pc_in[31:16];
                  OP_POP_PC:  hi_word <= mem_rdata;
                  OP_POP_CCR: begin
                     ccr_out  <= mem_rdata[2:0];
                     ccr_load <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_INT_VEC_HI: hi_word <= mem_rdata;
            S_POP_PC_LO, S_INT_VEC_LO: begin
               pc_out  <= {hi_word, mem_rdata};
               pc_load <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stack_ctrl.sv
// Bench for mem_stack_ctrl: table of single-cycle ops plus hand-written multi-cycle
// sequences; memory accesses are checked against an expected-access queue.
module tb_mem_stack_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] ALU_result, Rs_data, Rd_data;
   logic        memRead, memWrite, push, pop, pushPc, popPc, pushCCR, popCCR, int1, int2;
   logic [31:0] pc_in;
   logic [2:0]  ccr_in;
   logic [15:0] mem_rdata;
   logic [10:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we, mem_re;
   logic [15:0] mem_result;
   logic [31:0] pc_out;
   logic        pc_load;
   logic [2:0]  ccr_out;
   logic        ccr_load, stall;
   logic [10:0] sp;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_stack_ctrl dut (
      .clk(clk), .reset(reset), .ALU_result(ALU_result), .Rs_data(Rs_data), .Rd_data(Rd_data),
      .memRead(memRead), .memWrite(memWrite), .push(push), .pop(pop), .pushPc(pushPc),
      .popPc(popPc), .pushCCR(pushCCR), .popCCR(popCCR), .int1(int1), .int2(int2),
      .pc_in(pc_in), .ccr_in(ccr_in), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_result(mem_result),
      .pc_out(pc_out), .pc_load(pc_load), .ccr_out(ccr_out), .ccr_load(ccr_load),
      .stall(stall), .sp(sp)
   );

   // data memory: async read, write on the rising edge; preload port used only in reset
   logic [15:0] mem [0:2047];
   logic        pre_we = 1'b0;
   logic [10:0] pre_addr = '0;
   logic [15:0] pre_data = '0;
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [10:0] addr;
      logic [15:0] wdata;
      logic        stall;
   } acc_t;
   acc_t exp_q[$];

   task automatic expect_acc(input logic we, input logic [10:0] addr, input logic [15:0] wdata,
                             input logic st);
      acc_t a;
      a.we = we; a.addr = addr; a.wdata = wdata; a.stall = st;
      exp_q.push_back(a);
   endtask

   always @(negedge clk) begin
      if (mem_we || mem_re) begin
         if (exp_q.size() == 0) begin
            check("unexpected_access", {20'h0, mem_we, mem_addr}, 32'hFFFF_FFFF);
         end else begin
            acc_t e;
            e = exp_q.pop_front();
            check("acc_we_re", {30'h0, mem_we, mem_re}, {30'h0, e.we, ~e.we});
            check("acc_addr", {21'h0, mem_addr}, {21'h0, e.addr});
            if (e.we) check("acc_wdata", {16'h0, mem_wdata}, {16'h0, e.wdata});
            check("acc_stall", {31'h0, stall}, {31'h0, e.stall});
         end
      end
   end

   task automatic clear_inputs();
      {int2, int1, pushPc, popPc, pushCCR, popCCR, push, pop, memWrite, memRead} = '0;
      ALU_result = '0; Rs_data = '0; Rd_data = '0; pc_in = '0; ccr_in = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [9:0] R_INT2 = 10'h200, R_INT1 = 10'h100, R_PUSHPC = 10'h080,
      R_POPPC = 10'h040, R_PUSHCCR = 10'h020, R_POPCCR = 10'h010, R_PUSH = 10'h008,
      R_POP = 10'h004, R_WRITE = 10'h002, R_READ = 10'h001;

   typedef struct {
      logic [9:0]  req;
      logic [15:0] alu;
      logic [15:0] rd;
      logic [2:0]  ccr;
      logic        acc;
      logic        we;
      logic [10:0] addr;
      logic [15:0] wdata;
      logic [15:0] res;
      logic [10:0] sp;
      logic        ccr_ld;
      logic [2:0]  ccr_o;
   } vec_t;
   vec_t tbl [15];

   typedef struct {
      logic [10:0] addr;
      logic [15:0] data;
   } pre_t;
   pre_t pre [5];

   initial begin
      tbl[0]  = '{R_PUSH,            16'h1111, 16'hABCD, 3'd0, 1, 1, 11'h7FF, 16'hABCD, 16'h1111, 11'h7FE, 0, 3'd0};
      tbl[1]  = '{R_POP,             16'h0000, 16'h0000, 3'd0, 1, 0, 11'h7FF, 16'h0000, 16'hABCD, 11'h7FF, 0, 3'd0};
      tbl[2]  = '{R_WRITE,           16'h0123, 16'h5A5A, 3'd0, 1, 1, 11'h123, 16'h5A5A, 16'h0123, 11'h7FF, 0, 3'd0};
      tbl[3]  = '{R_READ,            16'h0123, 16'h0000, 3'd0, 1, 0, 11'h123, 16'h0000, 16'h5A5A, 11'h7FF, 0, 3'd0};
      tbl[4]  = '{R_READ,            16'hF923, 16'h0000, 3'd0, 1, 0, 11'h123, 16'h0000, 16'h5A5A, 11'h7FF, 0, 3'd0};
      tbl[5]  = '{R_PUSHCCR,         16'h2222, 16'hFFFF, 3'd6, 1, 1, 11'h7FF, 16'h0006, 16'h2222, 11'h7FE, 0, 3'd0};
      tbl[6]  = '{R_POPCCR,          16'h3333, 16'h0000, 3'd0, 1, 0, 11'h7FF, 16'h0000, 16'h3333, 11'h7FF, 1, 3'd6};
      tbl[7]  = '{10'h000,           16'h4444, 16'h0000, 3'd0, 0, 0, 11'h000, 16'h0000, 16'h4444, 11'h7FF, 0, 3'd6};
      tbl[8]  = '{R_POP,             16'h0000, 16'h0000, 3'd0, 1, 0, 11'h000, 16'h0000, 16'h0BAD, 11'h000, 0, 3'd6};
      tbl[9]  = '{R_PUSH,            16'h0001, 16'h7777, 3'd0, 1, 1, 11'h000, 16'h7777, 16'h0001, 11'h7FF, 0, 3'd6};
      tbl[10] = '{R_WRITE | R_READ,  16'h0050, 16'h1234, 3'd0, 1, 1, 11'h050, 16'h1234, 16'h0050, 11'h7FF, 0, 3'd6};
      tbl[11] = '{R_PUSH | R_POP | R_WRITE, 16'h0060, 16'h9999, 3'd0, 1, 1, 11'h7FF, 16'h9999, 16'h0060, 11'h7FE, 0, 3'd6};
      tbl[12] = '{R_POP | R_READ,    16'h0123, 16'h0000, 3'd0, 1, 0, 11'h7FF, 16'h0000, 16'h9999, 11'h7FF, 0, 3'd6};
      tbl[13] = '{R_POPCCR | R_PUSH, 16'h0070, 16'h1111, 3'd0, 1, 0, 11'h000, 16'h0000, 16'h0070, 11'h000, 1, 3'd7};
      tbl[14] = '{R_PUSHCCR | R_PUSH | R_READ, 16'h0080, 16'h2222, 3'd3, 1, 1, 11'h000, 16'h0003, 16'h0080, 11'h7FF, 0, 3'd7};

      pre[0] = '{11'h000, 16'h0BAD};
      pre[1] = '{11'h002, 16'h0000};
      pre[2] = '{11'h003, 16'h0100};
      pre[3] = '{11'h004, 16'h0003};
      pre[4] = '{11'h005, 16'h4000};

      // reset with requests asserted: nothing may reach memory or stall
      clear_inputs();
      reset = 1'b1;
      int1 = 1'b1; push = 1'b1; Rd_data = 16'hEEEE; pc_in = 32'h1234_5678;
      pre_we = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pre_addr = pre[i].addr;
         pre_data = pre[i].data;
         tick();
      end
      pre_we = 1'b0;
      #1;
      check("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check("rst_mem_re", {31'h0, mem_re}, 32'h0);
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_sp", {21'h0, sp}, 32'h7FF);
      check("rst_mem_result", {16'h0, mem_result}, 32'h0);
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_loads", {30'h0, pc_load, ccr_load}, 32'h0);
      check("rst_ccr_out", {29'h0, ccr_out}, 32'h0);
      tick();
      reset = 1'b0;
      clear_inputs();

      for (int i = 0; i < 15; i++) begin
         clear_inputs();
         {int2, int1, pushPc, popPc, pushCCR, popCCR, push, pop, memWrite, memRead} = tbl[i].req;
         ALU_result = tbl[i].alu;
         Rd_data    = tbl[i].rd;
         Rs_data    = 16'hC3C3;
         ccr_in     = tbl[i].ccr;
         pc_in      = 32'hDEAD_BEEF;
         if (tbl[i].acc) begin
            expect_acc(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0);
         end else begin
            #1;
            check($sformatf("idle_port[%0d]", i), {mem_we, mem_re, stall, mem_addr, mem_wdata},
                  32'h0);
         end
         tick();
         check($sformatf("result[%0d]", i), {16'h0, mem_result}, {16'h0, tbl[i].res});
         check($sformatf("sp[%0d]", i), {21'h0, sp}, {21'h0, tbl[i].sp});
         check($sformatf("ccr_load[%0d]", i), {31'h0, ccr_load}, {31'h0, tbl[i].ccr_ld});
         check($sformatf("ccr_out[%0d]", i), {29'h0, ccr_out}, {29'h0, tbl[i].ccr_o});
      end

      // pushPc: two writes, second-cycle inputs must be ignored
      clear_inputs();
      pushPc = 1'b1; pc_in = 32'h0001_0234; ALU_result = 16'h00AA;
      expect_acc(1'b1, 11'h7FF, 16'h0234, 1'b1);
      tick();
      pc_in = 32'hDEAD_BEEF; ALU_result = 16'h00BB; Rd_data = 16'hEEEE;
      expect_acc(1'b1, 11'h7FE, 16'h0001, 1'b0);
      tick();
      clear_inputs();
      check("pushpc_sp", {21'h0, sp}, 32'h7FD);
      check("pushpc_result_hold", {16'h0, mem_result}, 32'h00AA);
      check("pushpc_no_pc_load", {31'h0, pc_load}, 32'h0);

      // popPc
      popPc = 1'b1; ALU_result = 16'h00CC;
      expect_acc(1'b0, 11'h7FE, 16'h0, 1'b1);
      tick();
      clear_inputs(); pc_in = 32'hFFFF_FFFF;
      expect_acc(1'b0, 11'h7FF, 16'h0, 1'b0);
      tick();
      clear_inputs();
      check("poppc_pc_load", {31'h0, pc_load}, 32'h1);
      check("poppc_pc_out", pc_out, 32'h0001_0234);
      check("poppc_sp", {21'h0, sp}, 32'h7FF);
      check("poppc_result", {16'h0, mem_result}, 32'h00CC);
      tick();
      check("poppc_pc_load_pulse", {31'h0, pc_load}, 32'h0);

      // int1 entry; later-cycle requests and data are noise that must be ignored
      int1 = 1'b1; pc_in = 32'h0000_0010; ccr_in = 3'b101;
      expect_acc(1'b1, 11'h7FF, 16'h0010, 1'b1);
      tick();
      int1 = 1'b0; int2 = 1'b1; push = 1'b1; pc_in = 32'hFFFF_FFFF; ccr_in = 3'b111;
      Rd_data = 16'hEEEE;
      expect_acc(1'b1, 11'h7FE, 16'h0000, 1'b1);
      tick();
      expect_acc(1'b1, 11'h7FD, 16'h0005, 1'b1);
      tick();
      expect_acc(1'b0, 11'h002, 16'h0, 1'b1);
      tick();
      clear_inputs();
      expect_acc(1'b0, 11'h003, 16'h0, 1'b0);
      tick();
      check("int1_pc_load", {31'h0, pc_load}, 32'h1);
      check("int1_pc_out", pc_out, 32'h0000_0100);
      check("int1_sp", {21'h0, sp}, 32'h7FC);
      tick();
      check("int1_pc_load_pulse", {31'h0, pc_load}, 32'h0);

      // int2 beats a simultaneous push; no Rd_data write may appear
      int2 = 1'b1; push = 1'b1; Rd_data = 16'hEEEE; pc_in = 32'h0002_0030; ccr_in = 3'b010;
      expect_acc(1'b1, 11'h7FC, 16'h0030, 1'b1);
      tick();
      clear_inputs();
      expect_acc(1'b1, 11'h7FB, 16'h0002, 1'b1);
      tick();
      expect_acc(1'b1, 11'h7FA, 16'h0002, 1'b1);
      tick();
      expect_acc(1'b0, 11'h004, 16'h0, 1'b1);
      tick();
      expect_acc(1'b0, 11'h005, 16'h0, 1'b0);
      tick();
      check("int2_pc_load", {31'h0, pc_load}, 32'h1);
      check("int2_pc_out", pc_out, 32'h0003_4000);
      check("int2_sp", {21'h0, sp}, 32'h7F9);
      tick();

      // reset during INT_CCR aborts the sequence
      int1 = 1'b1; pc_in = 32'h0000_0055; ccr_in = 3'b001;
      expect_acc(1'b1, 11'h7F9, 16'h0055, 1'b1);
      tick();
      clear_inputs();
      expect_acc(1'b1, 11'h7F8, 16'h0000, 1'b1);
      tick();
      reset = 1'b1;
      #1;
      check("abort_rst_stall", {31'h0, stall}, 32'h0);
      check("abort_rst_we", {31'h0, mem_we}, 32'h0);
      tick();
      reset = 1'b0;
      #1;
      check("abort_idle_stall", {31'h0, stall}, 32'h0);
      check("abort_idle_we", {31'h0, mem_we}, 32'h0);
      check("abort_sp", {21'h0, sp}, 32'h7FF);
      check("abort_pc_load", {31'h0, pc_load}, 32'h0);
      check("abort_pc_out", pc_out, 32'h0);
      tick();
      check("abort_pc_load_late", {31'h0, pc_load}, 32'h0);
      tick();

      check("scoreboard_drained", exp_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stack_ctrl.md
# mem_stack_ctrl

Memory-stage controller that consumes the EX/MEM pipeline register fields and sequences all data-memory traffic: plain loads and stores, single-word stack push/pop, two-word PC push/pop, CCR push/pop, and the hardware interrupt entry sequence. It owns the stack pointer (SP). It drives the data-memory port and raises `stall` toward earlier stages while a multi-cycle operation is in progress. Results go to the MEM/WB register and the PC/CCR load paths.

## Interface
- `ADDR_W`, 11: data-memory address width; SP width.
- `SP_INIT`, 2^ADDR_W-1 (11'h7FF): SP value after reset.
- `INT1_VEC`, 2: address of the int1 vector (high word; low word at +1).
- `INT2_VEC`, 4: address of the int2 vector (high word; low word at +1).

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ALU_result` in 16: load/store address (low `ADDR_W` bits), and passthrough result.
- `Rs_data`, `Rd_data` in 16 each: `Rd_data` is the store/push write data.
- `memRead`, `memWrite`, `push`, `pop`, `pushPc`, `popPc`, `pushCCR`, `popCCR`, `int1`, `int2` in 1 each: operation requests, sampled only in IDLE.
- `pc_in` in 32: PC to save. `ccr_in` in 3: flags to save.
- `mem_rdata` in 16: asynchronous-read data for the current `mem_addr`.
- `mem_addr` out ADDR_W; `mem_wdata` out 16; `mem_we` out 1; `mem_re` out 1: combinational memory port.
- `mem_result` out 16: registered stage result.
- `pc_out` out 32; `pc_load` out 1: registered PC restore/vector, with a one-cycle pulse.
- `ccr_out` out 3; `ccr_load` out 1: registered CCR restore, with a one-cycle pulse.
- `stall` out 1: combinational; hold upstream while high.
- `sp` out ADDR_W: current SP.

## Operation
- The stack is full-descending.
  - Push: write `mem[SP]`, then SP <= SP-1.
  - Pop: read `mem[SP+1]`, then SP <= SP+1.
  - SP arithmetic is modulo 2^ADDR_W. There is no overflow or underflow detection.
- Request priority in IDLE: int2 > int1 > pushPc > popPc > pushCCR > popCCR > push > pop > memWrite > memRead. A lower-priority request asserted in the same cycle is discarded; the hazard unit must flush it.
- Single-cycle operations (stay in IDLE):
  - memRead: read `mem[ALU_result]`.
  - memWrite: write `Rd_data` to `mem[ALU_result]`.
  - push: write `Rd_data`.
  - pop: read.
  - pushCCR: write `{13'b0, ccr_in}`.
  - popCCR: read; `ccr_out` <= `mem_rdata[2:0]`; `ccr_load` pulses.
- pushPc:
  - IDLE: write `pc_in[15:0]`; latch `pc_in[31:16]`; go to PUSH_PC_HI.
  - PUSH_PC_HI: write the latched high word; go to IDLE.
- popPc:
  - IDLE: pop the high word into a latch; go to POP_PC_LO.
  - POP_PC_LO: pop the low word; `pc_out` <= {hi, lo}; `pc_load` pulses; go to IDLE.
- int1/int2:
  - IDLE: push `pc_in[15:0]`; latch `pc_in[31:16]`, `ccr_in`, and the vector address.
  - INT_PC_HI: push the high word.
  - INT_CCR: push the CCR.
  - INT_VEC_HI: read `mem[VEC]` into a latch.
  - INT_VEC_LO: read `mem[VEC+1]`; `pc_out` <= {hi, lo}; `pc_load` pulses; go to IDLE.
- Outside IDLE, all request inputs and data inputs are ignored; only latched copies are used.
- `mem_result` <= `mem_rdata` on memRead/pop, else `ALU_result`. It updates every cycle in IDLE and holds outside IDLE.
- `mem_we`/`mem_re` are high only in cycles performing that access. `mem_addr`/`mem_wdata` are 0 when idle with no request.

## Timing
- Reset (cycle with `reset`=1):
  - Next state IDLE; SP = SP_INIT.
  - `mem_result`, `pc_out`, `ccr_out`, `pc_load`, `ccr_load` = 0.
  - `mem_we`, `mem_re`, `stall` are forced 0 during the reset cycle.
- Reset mid-sequence aborts the sequence. There is no write in the reset cycle and no `pc_load`.
- Latency per operation:
  - Single-cycle ops: result or pulse visible the cycle after the request.
  - pushPc/popPc: 2 cycles.
  - Interrupt: 5 cycles.
- `stall` is high in every cycle of a multi-cycle op except its last, i.e. 1 cycle for pushPc/popPc and 4 cycles for interrupt.
- `pc_load`/`ccr_load` are high for exactly one cycle, the cycle after the completing access.
- SP update, latches, and registered outputs all occur on the same edge that ends the access cycle.

## Test plan
- Reset, then push `Rd_data`=0xABCD → `mem_we`=1, addr 0x7FF, wdata 0xABCD; `sp`=0x7FE. Then pop → `mem_re`, addr 0x7FF; `mem_result`=0xABCD; `sp`=0x7FF.
- pushPc with `pc_in`=0x0001_0234 → writes 0x0234@0x7FF (`stall`=1), then 0x0001@0x7FE (`stall`=0); `sp`=0x7FD. Then popPc → `pc_out`=0x00010234, `pc_load` 1 cycle, `sp`=0x7FF.
- int1 with `pc_in`=0x10, `ccr_in`=3'b101, mem[2]=0x0000, mem[3]=0x0100 → writes 0x0010@7FF, 0x0000@7FE, 0x0005@7FD; reads addr 2 then 3; `stall` high 4 cycles; `pc_out`=0x00000100; `pc_load` pulse; `sp`=0x7FC.
- int2 and push asserted together → int2 sequence uses INT2_VEC=4; no write of `Rd_data` occurs.
- `reset` asserted while in INT_CCR → next cycle IDLE, `stall`=0, `sp`=0x7FF, no `mem_we`, no `pc_load`.
- pop at `sp`=0x7FF → reads addr 0x000; `sp`=0x000 (wrap).
